// File: rtl/tg_bus_master.sv
// tg_bus_master: single-request bus master with fixed-length bus cycles.
// Every bus cycle is SETUP (c=0), STROBE (c=1..N-2), HOLD (c=N-1), where N is
// FAST_CLKS or SLOW_CLKS depending on the latched hsm bit.
// Optional feature: define TGBUS_BITREV_EN to bit-reverse the data lanes when region=1.
//
// state  | meaning
// IDLE   | ready for a request, strobes high, bus address held
// SETUP  | address valid, strobes high, write data driven
// STROBE | read or write strobe low
// HOLD   | strobes high, response pulse issued
module tg_bus_master #(
    parameter int SLOW_CLKS = 24,
    parameter int FAST_CLKS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_hsm,
    input  logic [20:0] req_addr,
    input  logic [7:0]  req_dato,
    output logic        rsp_valid,
    output logic        rsp_we,
    output logic [7:0]  rsp_dati,
    output logic [20:0] bus_addr,
    output logic        bus_hsm,
    output logic        bus_oe_n,
    output logic        bus_we_n,
    output logic [7:0]  bus_dato,
    output logic        bus_dato_oe,
    input  logic [7:0]  bus_dati,
    input  logic        region
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  c_q, c_d;
    logic        we_q, we_d;
    logic        hsm_q, hsm_d;
    logic [7:0]  dato_q, dato_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_we_q, rsp_we_d;
    logic [7:0]  rsp_dati_q, rsp_dati_d;
    logic [20:0] bus_addr_q, bus_addr_d;
    logic        bus_hsm_q, bus_hsm_d;
    logic        bus_oe_n_q, bus_oe_n_d;
    logic        bus_we_n_q, bus_we_n_d;
    logic [7:0]  bus_dato_q, bus_dato_d;
    logic        bus_dato_oe_q, bus_dato_oe_d;

    logic [7:0]  n_clks;
    logic        data_swap;

`ifdef TGBUS_BITREV_EN
    assign data_swap = region;
`else
    logic unused_region;
    assign unused_region = region;
    assign data_swap     = 1'b0;
`endif

    assign n_clks = hsm_q ? 8'(FAST_CLKS) : 8'(SLOW_CLKS);

    function automatic logic [7:0] map_data(input logic [7:0] d, input logic swap);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = d[7-i];
        return swap ? r : d;
    endfunction

    // Next-state and next-output computation for the bus cycle sequencer.
    always_comb begin
        state_d       = state_q;
        c_d           = c_q;
        we_d          = we_q;
        hsm_d         = hsm_q;
        dato_d        = dato_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = 1'b0;
        rsp_we_d      = rsp_we_q;
        rsp_dati_d    = rsp_dati_q;
        bus_addr_d    = bus_addr_q;
        bus_hsm_d     = bus_hsm_q;
        bus_oe_n_d    = 1'b1;
        bus_we_n_d    = 1'b1;
        bus_dato_d    = bus_dato_q;
        bus_dato_oe_d = bus_dato_oe_q;

        case (state_q)
            S_IDLE: begin
                req_ready_d   = 1'b1;
                bus_dato_oe_d = 1'b0;
                c_d           = 8'd0;
                if (req_valid && req_ready_q) begin
                    we_d          = req_we;
                    hsm_d         = req_hsm;
                    dato_d        = req_dato;
                    bus_addr_d    = req_addr;
                    bus_hsm_d     = req_hsm;
                    req_ready_d   = 1'b0;
                    state_d       = S_SETUP;
                    bus_dato_oe_d = req_we;
                    if (req_we) bus_dato_d = map_data(req_dato, data_swap);
                end
            end
            S_SETUP: begin
                state_d    = S_STROBE;
                c_d        = 8'd1;
                bus_oe_n_d = we_q;
                bus_we_n_d = ~we_q;
                if (we_q) bus_dato_d = map_data(dato_q, data_swap);
            end
            S_STROBE: begin
                if (we_q) bus_dato_d = map_data(dato_q, data_swap);
                if (c_q == n_clks - 8'd2) begin
                    // Last strobe clock: capture read data and release the strobe.
                    state_d     = S_HOLD;
                    c_d         = n_clks - 8'd1;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = we_q;
                    if (!we_q) rsp_dati_d = map_data(bus_dati, data_swap);
                end else begin
                    c_d        = c_q + 8'd1;
                    bus_oe_n_d = we_q;
                    bus_we_n_d = ~we_q;
                end
            end
            S_HOLD: begin
                state_d       = S_IDLE;
                c_d           = 8'd0;
                bus_dato_oe_d = 1'b0;
                req_ready_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                c_d     = 8'd0;
            end
        endcase
    end

    // State and registered outputs, synchronous reset aborts any cycle in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            c_q           <= 8'd0;
            we_q          <= 1'b0;
            hsm_q         <= 1'b0;
            dato_q        <= 8'd0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_we_q      <= 1'b0;
            rsp_dati_q    <= 8'd0;
            bus_addr_q    <= 21'd0;
            bus_hsm_q     <= 1'b0;
            bus_oe_n_q    <= 1'b1;
            bus_we_n_q    <= 1'b1;
            bus_dato_q    <= 8'd0;
            bus_dato_oe_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            c_q           <= c_d;
            we_q          <= we_d;
            hsm_q         <= hsm_d;
            dato_q        <= dato_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_we_q      <= rsp_we_d;
            rsp_dati_q    <= rsp_dati_d;
            bus_addr_q    <= bus_addr_d;
            bus_hsm_q     <= bus_hsm_d;
            bus_oe_n_q    <= bus_oe_n_d;
            bus_we_n_q    <= bus_we_n_d;
            bus_dato_q    <= bus_dato_d;
            bus_dato_oe_q <= bus_dato_oe_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_we      = rsp_we_q;
    assign rsp_dati    = rsp_dati_q;
    assign bus_addr    = bus_addr_q;
    assign bus_hsm     = bus_hsm_q;
    assign bus_oe_n    = bus_oe_n_q;
    assign bus_we_n    = bus_we_n_q;
    assign bus_dato    = bus_dato_q;
    assign bus_dato_oe = bus_dato_oe_q;

endmodule
